tilebuffer_writer: RTL and testbench

- Producer-side sequencer for the flip-flop tilebuffer block.
- Accepts a ready/valid stream of pixel words (N_I ternary channels, 2 bits each, row-major).
- Drives the buffer's data, save-enable and flush inputs, one buffer row at a time.
- Per row: flushes the buffer, inserts optional left/right zero padding, and flags each cycle in which the buffer holds a complete DEPTH-wide window.

---
 rtl/tilebuffer_writer_pkg.sv | 26 ++
 rtl/tilebuffer_writer_stats.sv | 16 +
 rtl/tilebuffer_writer.sv | 159 +++++++++++++++
 tb/tb_tilebuffer_writer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tilebuffer_writer_pkg.sv
// Shared types and sizing helpers for the tilebuffer producer-side sequencer.
package tilebuffer_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LPAD,
        S_STREAM,
        S_RPAD,
        S_DONE
    } state_e;

    localparam int unsigned PIXEL_N_I = 256;
    typedef logic [0:PIXEL_N_I-1][1:0] pixel_t;

    // Zero pixels inserted at each row edge.
    function automatic int unsigned pad_width(input logic padding, input int unsigned depth);
        return padding ? depth / 2 : 0;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tilebuffer_writer_stats.sv
// Window counter; only built when TILEBUFFER_WRITER_STATS_EN is defined.
module tilebuffer_writer_stats (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      count_o <= '0;
        else if (clr_i)   count_o <= '0;
        else if (inc_i)   count_o <= count_o + 32'd1;
    end

endmodule

// File: rtl/tilebuffer_writer.sv
// Producer-side sequencer feeding the flip-flop tilebuffer one row at a time.
// Optional window statistics counter: define TILEBUFFER_WRITER_STATS_EN.
module tilebuffer_writer
    import tilebuffer_writer_pkg::*;
#(
    parameter int unsigned N_I        = 256,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned MAX_WIDTH  = 64,
    parameter int unsigned MAX_HEIGHT = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]    width_i,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0]   height_i,
    input  logic                              padding_i,
    input  logic [0:N_I-1][1:0]               data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [0:N_I-1][1:0]               data_o,
    output logic                              save_enable_o,
    output logic                              flush_o,
    output logic                              window_valid_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [31:0]                       win_count_o
);

    localparam int unsigned WW   = cnt_width(MAX_WIDTH);
    localparam int unsigned HW   = cnt_width(MAX_HEIGHT);
    localparam int unsigned PMAX = DEPTH / 2;
    localparam int unsigned PW   = cnt_width(PMAX);
    localparam int unsigned FW   = cnt_width(DEPTH);

    state_e         state_q;
    logic [WW-1:0]  width_q, col_q;
    logic [HW-1:0]  height_q, row_q;
    logic [PW-1:0]  pad_q, pad_cnt_q;
    logic [FW-1:0]  fill_q, fill_inc;
    logic [1:0]     vld_pipe;

    logic hs, push, has_pad, pad_last, col_last, row_last, row_end;

    assign ready_o  = (state_q == S_STREAM);
    assign busy_o   = (state_q != S_IDLE);
    assign hs       = valid_i && ready_o;
    assign push     = (state_q == S_LPAD) || (state_q == S_RPAD) || hs;
    assign has_pad  = (pad_q != '0);
    assign pad_last = (pad_cnt_q == pad_q - PW'(1));
    assign col_last = (col_q == width_q - WW'(1));
    assign row_last = (row_q == height_q - HW'(1));
    assign row_end  = ((state_q == S_STREAM) && hs && col_last && !has_pad) ||
                      ((state_q == S_RPAD) && pad_last);
    assign fill_inc = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);

    // vld_pipe[0] rides with save_enable_o, vld_pipe[1] with the buffer capture.
    assign window_valid_o = vld_pipe[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            width_q       <= '0;
            height_q      <= '0;
            pad_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pad_cnt_q     <= '0;
            fill_q        <= '0;
            vld_pipe      <= '0;
            data_o        <= '0;
            save_enable_o <= 1'b0;
            flush_o       <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            save_enable_o <= push;
            flush_o       <= (state_q == S_FLUSH);
            vld_pipe      <= {vld_pipe[0], push && (fill_inc == FW'(DEPTH))};
            if (push) begin
                data_o <= hs ? data_i : '0;
                fill_q <= fill_inc;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        width_q   <= width_i;
                        height_q  <= height_i;
                        pad_q     <= PW'(pad_width(padding_i, DEPTH));
                        col_q     <= '0;
                        row_q     <= '0;
                        pad_cnt_q <= '0;
                        if (width_i == '0 || height_i == '0) begin
                            state_q <= S_DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    fill_q  <= '0;
                    state_q <= has_pad ? S_LPAD : S_STREAM;
                end
                S_LPAD: begin
                    if (pad_last) begin
                        pad_cnt_q <= '0;
                        state_q   <= S_STREAM;
                    end else begin
                        pad_cnt_q <= pad_cnt_q + PW'(1);
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (has_pad) state_q <= S_RPAD;
                        end else begin
                            col_q <= col_q + WW'(1);
                        end
                    end
                end
                S_RPAD: begin
                    pad_cnt_q <= pad_last ? '0 : pad_cnt_q + PW'(1);
                end
                S_DONE: begin
                    // First DONE cycle drains the final save; done_o follows it.
                    if (done_o) begin
                        done_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done_o  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (row_end) begin
                row_q   <= row_q + HW'(1);
                state_q <= row_last ? S_DONE : S_FLUSH;
            end
        end
    end

`ifdef TILEBUFFER_WRITER_STATS_EN
    logic start_acc;
    assign start_acc = (state_q == S_IDLE) && start_i;

    tilebuffer_writer_stats u_stats (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (start_acc),
        .inc_i   (window_valid_o),
        .count_o (win_count_o)
    );
`else
    assign win_count_o = '0;
`endif

endmodule

// File: tb/tb_tilebuffer_writer.sv
// Self-checking bench: golden tilebuffer model plus a window scoreboard.
module tb_tilebuffer_writer;

    localparam int N_I   = 8;
    localparam int DEPTH = 3;
    localparam int MAX_W = 64;
    localparam int MAX_H = 64;
    localparam int WW    = $clog2(MAX_W + 1);
    localparam int HW    = $clog2(MAX_H + 1);

    typedef logic [0:N_I-1][1:0]            word_t;
    typedef logic [0:DEPTH-1][0:N_I-1][1:0] win_t;

    typedef struct {
        int w;
        int h;
        int pad;
        int gap;
        int exp_win;
        int exp_flush;
        int exp_save;
    } vec_t;

    logic          clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, padding_i = 1'b0, valid_i = 1'b0;
    logic [WW-1:0] width_i = '0;
    logic [HW-1:0] height_i = '0;
    word_t         data_i = '0, data_o;
    logic          ready_o, save_enable_o, flush_o, window_valid_o, busy_o, done_o;
    logic [31:0]   win_count_o;

    tilebuffer_writer #(
        .N_I(N_I), .DEPTH(DEPTH), .MAX_WIDTH(MAX_W), .MAX_HEIGHT(MAX_H)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .width_i(width_i), .height_i(height_i), .padding_i(padding_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .save_enable_o(save_enable_o), .flush_o(flush_o),
        .window_valid_o(window_valid_o), .busy_o(busy_o), .done_o(done_o),
        .win_count_o(win_count_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_vec = 0, n_err = 0;
    int   cnt_win = 0, cnt_save = 0, cnt_flush = 0, cnt_done = 0;
    win_t bufm;
    win_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Golden model of the external tilebuffer: element 0 is the oldest pixel.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) bufm <= '0;
        else if (flush_o) bufm <= '0;
        else if (save_enable_o) begin
            for (int j = 0; j < DEPTH - 1; j++) bufm[j] <= bufm[j+1];
            bufm[DEPTH-1] <= data_o;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (save_enable_o || flush_o) chk("save_flush_excl", 64'(save_enable_o & flush_o), 64'd0);
            if (done_o) chk("done_after_last_save", 64'(save_enable_o), 64'd0);
            if (save_enable_o) cnt_save++;
            if (flush_o) cnt_flush++;
            if (done_o) cnt_done++;
            if (window_valid_o) begin
                cnt_win++;
                if (exp_q.size() == 0) chk("window_unexpected", 64'd1, 64'd0);
                else chk("window_content", 64'(bufm), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input word_t w, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            valid_i = 1'b0;
            @(negedge clk_i);
        end
        valid_i = 1'b1;
        data_i  = w;
        t = 0;
        while (!ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!ready_o) chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        word_t pix[$];
        word_t seq[$];
        win_t  e;
        int    p, t, wins;
        p = v.pad ? DEPTH / 2 : 0;
        for (int i = 0; i < v.w * v.h; i++) pix.push_back(word_t'($urandom));
        wins = 0;
        for (int r = 0; r < v.h; r++) begin
            seq.delete();
            for (int i = 0; i < p; i++) seq.push_back('0);
            for (int c = 0; c < v.w; c++) seq.push_back(pix[r*v.w + c]);
            for (int i = 0; i < p; i++) seq.push_back('0);
            for (int k = 0; k + DEPTH <= seq.size(); k++) begin
                for (int j = 0; j < DEPTH; j++) e[j] = seq[k+j];
                exp_q.push_back(e);
                wins++;
            end
        end
        chk("table_window_count", 64'(wins), 64'(v.exp_win));
        cnt_win = 0; cnt_save = 0; cnt_flush = 0; cnt_done = 0;
        width_i   = WW'(v.w);
        height_i  = HW'(v.h);
        padding_i = v.pad[0];
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'd1);
        foreach (pix[i]) send(pix[i], v.gap ? int'($urandom_range(0, v.gap)) : 0);
        t = 0;
        while (cnt_done == 0 && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        repeat (3) @(negedge clk_i);
        chk("done_count", 64'(cnt_done), 64'd1);
        chk("window_count", 64'(cnt_win), 64'(v.exp_win));
        chk("flush_count", 64'(cnt_flush), 64'(v.exp_flush));
        chk("save_count", 64'(cnt_save), 64'(v.exp_save));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_after_done", 64'(busy_o), 64'd0);
`ifdef TILEBUFFER_WRITER_STATS_EN
        chk("win_count", 64'(win_count_o), 64'(v.exp_win));
`else
        chk("win_count", 64'(win_count_o), 64'd0);
`endif
    endtask

    task automatic chk_quiet(input string name);
        chk(name, 64'({ready_o, save_enable_o, flush_o, window_valid_o, busy_o, done_o,
                       data_o, win_count_o}), 64'd0);
    endtask

    task automatic empty_job(input int w, input int h);
        cnt_save = 0; cnt_flush = 0;
        width_i  = WW'(w);
        height_i = HW'(h);
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("empty_done_next", 64'(done_o), 64'd1);
        @(negedge clk_i);
        chk("empty_done_pulse", 64'(done_o), 64'd0);
        chk("empty_idle", 64'(busy_o), 64'd0);
        chk("empty_no_writes", 64'(cnt_save + cnt_flush), 64'd0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{4, 1, 1, 0, 4, 1, 6};
        tbl[1] = '{4, 2, 0, 0, 4, 2, 8};
        tbl[2] = '{8, 3, 0, 0, 18, 3, 24};
        tbl[3] = '{8, 3, 0, 3, 18, 3, 24};
        tbl[4] = '{2, 1, 0, 0, 0, 1, 2};
        tbl[5] = '{5, 2, 1, 2, 10, 2, 14};
        tbl[6] = '{1, 1, 1, 0, 1, 1, 3};
        tbl[7] = '{2, 2, 0, 1, 0, 2, 4};

        repeat (3) @(negedge clk_i);
        chk_quiet("reset_state");
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        empty_job(0, 2);
        empty_job(4, 0);

        // Abort mid-row: reset must clear everything at once.
        width_i = WW'(8); height_i = HW'(1); padding_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) send(word_t'($urandom), 0);
        chk("stream_before_reset", 64'(ready_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk_quiet("async_reset");
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_job(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
